// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and types for the Viterbi storage blocks
package viterbi_pkg;

    localparam int NUM_STATES       = 4;
    localparam int DEC_W            = 4;
    localparam int TBL_DEFAULT      = 15;
    localparam int PM_WIDTH_DEFAULT = 8;

    typedef logic [PM_WIDTH_DEFAULT-1:0] pm_word_t;
    typedef logic [DEC_W-1:0]            dec_vec_t;

endpackage

// File: rtl/decision_history_sreg.sv
// rtl/decision_history_sreg.sv - TBL-deep survivor decision shift history with random read
module decision_history_sreg
    import viterbi_pkg::*;
#(
    parameter int TBL = TBL_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [DEC_W-1:0]       dec_bits_i,
    input  logic [$clog2(TBL)-1:0] read_addr_i,
    output logic [DEC_W-1:0]       read_data_o
);

    // Entry 0 is the oldest decision vector, entry TBL-1 the newest.
    dec_vec_t hist_q [TBL];
    dec_vec_t hist_d [TBL];

    // Shift toward entry 0 on each trellis step; the oldest vector falls off silently.
    always_comb begin
        hist_d = hist_q;
        if (valid_i) begin
            for (int k = 0; k < TBL - 1; k++) begin
                hist_d[k] = hist_q[k + 1];
            end
            hist_d[TBL - 1] = dec_bits_i;
        end
    end

    // History register; reset wins over a simultaneous step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TBL; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    // Combinational read; addresses past the last entry return zero instead of X.
    always_comb begin
        read_data_o = '0;
        if (int'(read_addr_i) < TBL) begin
            read_data_o = hist_q[read_addr_i];
        end
    end

endmodule

// File: rtl/path_metric_unit.sv
// rtl/path_metric_unit.sv - path metric registers and decision history for a 4-state trellis
module path_metric_unit
    import viterbi_pkg::*;
#(
    parameter int TBL      = TBL_DEFAULT,
    parameter int PM_WIDTH = PM_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [DEC_W-1:0]       dec_bits_i,
    input  logic [PM_WIDTH-1:0]    pm_new_s0_i,
    input  logic [PM_WIDTH-1:0]    pm_new_s1_i,
    input  logic [PM_WIDTH-1:0]    pm_new_s2_i,
    input  logic [PM_WIDTH-1:0]    pm_new_s3_i,
    input  logic [$clog2(TBL)-1:0] read_addr_i,
    output logic [PM_WIDTH-1:0]    pm_current_s0_o,
    output logic [PM_WIDTH-1:0]    pm_current_s1_o,
    output logic [PM_WIDTH-1:0]    pm_current_s2_o,
    output logic [PM_WIDTH-1:0]    pm_current_s3_o,
    output logic [DEC_W-1:0]       read_data_o
);

    logic [PM_WIDTH-1:0] pm_q [NUM_STATES];
    logic [PM_WIDTH-1:0] pm_d [NUM_STATES];

    // Metrics are captured verbatim from ACS on a step; normalisation lives upstream.
    always_comb begin
        pm_d = pm_q;
        if (valid_i) begin
            pm_d[0] = pm_new_s0_i;
            pm_d[1] = pm_new_s1_i;
            pm_d[2] = pm_new_s2_i;
            pm_d[3] = pm_new_s3_i;
        end
    end

    // Path metric registers; reset wins over a simultaneous step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_STATES; n++) begin
                pm_q[n] <= '0;
            end
        end else begin
            pm_q <= pm_d;
        end
    end

    assign pm_current_s0_o = pm_q[0];
    assign pm_current_s1_o = pm_q[1];
    assign pm_current_s2_o = pm_q[2];
    assign pm_current_s3_o = pm_q[3];

    decision_history_sreg #(
        .TBL (TBL)
    ) u_history (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .dec_bits_i  (dec_bits_i),
        .read_addr_i (read_addr_i),
        .read_data_o (read_data_o)
    );

endmodule

// File: tb/tb_path_metric_unit.sv
// tb/tb_path_metric_unit.sv - self-checking bench for path_metric_unit against a queue model
module tb_path_metric_unit;

    localparam int TBL = 15;
    localparam int PMW = 8;
    localparam int AW  = $clog2(TBL);

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_i;
    logic [3:0]     dec_bits_i;
    logic [PMW-1:0] pm_new_s0_i, pm_new_s1_i, pm_new_s2_i, pm_new_s3_i;
    logic [AW-1:0]  read_addr_i;
    logic [PMW-1:0] pm_current_s0_o, pm_current_s1_o, pm_current_s2_o, pm_current_s3_o;
    logic [3:0]     read_data_o;

    logic [PMW-1:0] pm_obs [4];
    assign pm_obs[0] = pm_current_s0_o;
    assign pm_obs[1] = pm_current_s1_o;
    assign pm_obs[2] = pm_current_s2_o;
    assign pm_obs[3] = pm_current_s3_o;

    // Reference model: history as a queue, oldest at the front.
    logic [3:0]     m_hist [$];
    logic [PMW-1:0] m_pm   [4];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    path_metric_unit #(.TBL(TBL), .PM_WIDTH(PMW)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i         (valid_i),
        .dec_bits_i      (dec_bits_i),
        .pm_new_s0_i     (pm_new_s0_i),
        .pm_new_s1_i     (pm_new_s1_i),
        .pm_new_s2_i     (pm_new_s2_i),
        .pm_new_s3_i     (pm_new_s3_i),
        .read_addr_i     (read_addr_i),
        .pm_current_s0_o (pm_current_s0_o),
        .pm_current_s1_o (pm_current_s1_o),
        .pm_current_s2_o (pm_current_s2_o),
        .pm_current_s3_o (pm_current_s3_o),
        .read_data_o     (read_data_o)
    );

    function automatic logic [3:0] model_read(input int addr);
        if (addr >= TBL) return 4'b0000;
        return m_hist[addr];
    endfunction

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input logic r, input logic v, input logic [3:0] d,
                        input logic [PMW-1:0] p0, input logic [PMW-1:0] p1,
                        input logic [PMW-1:0] p2, input logic [PMW-1:0] p3);
        rst = r; valid_i = v; dec_bits_i = d;
        pm_new_s0_i = p0; pm_new_s1_i = p1; pm_new_s2_i = p2; pm_new_s3_i = p3;
        @(posedge clk);
        #1;
        if (r) begin
            m_hist.delete();
            for (int k = 0; k < TBL; k++) m_hist.push_back(4'b0000);
            for (int n = 0; n < 4; n++) m_pm[n] = '0;
        end else if (v) begin
            void'(m_hist.pop_front());
            m_hist.push_back(d);
            m_pm[0] = p0; m_pm[1] = p1; m_pm[2] = p2; m_pm[3] = p3;
        end
        rst = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 4'h0, 8'd9, 8'd9, 8'd9, 8'd9);
        step(1'b1, 1'b0, 4'h0, 8'd9, 8'd9, 8'd9, 8'd9);
        step(1'b0, 1'b0, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (pm_obs[n] !== 8'd0) $display("FAIL reset_pm%0d got %0d want 0", n, pm_obs[n]);
            else passed++;
        end
        for (int a = 0; a < 16; a++) begin
            read_addr_i = AW'(a); #1;
            checks++;
            if (read_data_o !== 4'b0000) $display("FAIL reset_hist[%0d] got %b want 0000", a, read_data_o);
            else passed++;
        end
    endtask

    task automatic test_single_write();
        step(1'b0, 1'b1, 4'b1010, 8'd10, 8'd20, 8'd30, 8'd40);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (pm_obs[n] !== 8'(10 * (n + 1))) $display("FAIL single_pm%0d got %0d want %0d", n, pm_obs[n], 10 * (n + 1));
            else passed++;
        end
        read_addr_i = 4'd14; #1;
        checks++;
        if (read_data_o !== 4'b1010) $display("FAIL single_addr14 got %b want 1010", read_data_o);
        else passed++;
        read_addr_i = 4'd13; #1;
        checks++;
        if (read_data_o !== 4'b0000) $display("FAIL single_addr13 got %b want 0000", read_data_o);
        else passed++;
    endtask

    task automatic test_four_writes();
        step(1'b0, 1'b1, 4'b0001, 8'd110, 8'd120, 8'd130, 8'd140);
        step(1'b0, 1'b1, 4'b0010, 8'd130, 8'd140, 8'd150, 8'd160);
        step(1'b0, 1'b1, 4'b0100, 8'd150, 8'd160, 8'd170, 8'd180);
        step(1'b0, 1'b1, 4'b1000, 8'd170, 8'd180, 8'd190, 8'd200);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (pm_obs[n] !== 8'(170 + 10 * n)) $display("FAIL four_pm%0d got %0d want %0d", n, pm_obs[n], 170 + 10 * n);
            else passed++;
        end
        for (int a = 0; a < 16; a++) begin
            read_addr_i = AW'(a); #1;
            checks++;
            if (read_data_o !== model_read(a)) $display("FAIL four_hist[%0d] got %b want %b", a, read_data_o, model_read(a));
            else passed++;
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < TBL; i++) step(1'b0, 1'b1, 4'b1111, 8'd255, 8'd254, 8'd253, 8'd252);
        read_addr_i = 4'd0; #1;
        checks++;
        if (read_data_o !== 4'b1111) $display("FAIL fill_addr0 got %b want 1111", read_data_o);
        else passed++;
        read_addr_i = 4'd14; #1;
        checks++;
        if (read_data_o !== 4'b1111) $display("FAIL fill_addr14 got %b want 1111", read_data_o);
        else passed++;
        step(1'b0, 1'b1, 4'b0000, 8'd1, 8'd2, 8'd3, 8'd4);
        for (int a = 0; a < TBL; a++) begin
            read_addr_i = AW'(a); #1;
            checks++;
            if (read_data_o !== ((a == TBL - 1) ? 4'b0000 : 4'b1111))
                $display("FAIL overflow_hist[%0d] got %b want %b", a, read_data_o, (a == TBL - 1) ? 4'b0000 : 4'b1111);
            else passed++;
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (pm_obs[n] !== 8'(n + 1)) $display("FAIL overflow_pm%0d got %0d want %0d", n, pm_obs[n], n + 1);
            else passed++;
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0110, 8'd0, 8'd0, 8'(i), 8'(77 + i));
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (pm_obs[n] !== 8'(n + 1)) $display("FAIL hold_pm%0d got %0d want %0d", n, pm_obs[n], n + 1);
            else passed++;
        end
        for (int a = 0; a < TBL; a++) begin
            read_addr_i = AW'(a); #1;
            checks++;
            if (read_data_o !== model_read(a)) $display("FAIL hold_hist[%0d] got %b want %b", a, read_data_o, model_read(a));
            else passed++;
        end
    endtask

    task automatic test_out_of_range();
        read_addr_i = 4'd15; #1;
        checks++;
        if (read_data_o !== 4'b0000) $display("FAIL oob_addr15 got %b want 0000", read_data_o);
        else passed++;
    endtask

    task automatic test_reset_with_valid();
        step(1'b0, 1'b1, 4'b1001, 8'd50, 8'd60, 8'd70, 8'd80);
        step(1'b1, 1'b1, 4'b1111, 8'd99, 8'd98, 8'd97, 8'd96);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (pm_obs[n] !== 8'd0) $display("FAIL rstvalid_pm%0d got %0d want 0", n, pm_obs[n]);
            else passed++;
        end
        for (int a = 0; a < TBL; a++) begin
            read_addr_i = AW'(a); #1;
            checks++;
            if (read_data_o !== 4'b0000) $display("FAIL rstvalid_hist[%0d] got %b want 0000", a, read_data_o);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 4'b0011, 8'd5, 8'd6, 8'd7, 8'd8);
        step(1'b0, 1'b1, 4'b0101, 8'd15, 8'd16, 8'd17, 8'd18);
        step(1'b0, 1'b1, 4'b0110, 8'd25, 8'd26, 8'd27, 8'd28);
        read_addr_i = 4'd12; #1;
        checks++;
        if (read_data_o !== 4'b0011) $display("FAIL b2b_addr12 got %b want 0011", read_data_o);
        else passed++;
        read_addr_i = 4'd13; #1;
        checks++;
        if (read_data_o !== 4'b0101) $display("FAIL b2b_addr13 got %b want 0101", read_data_o);
        else passed++;
        read_addr_i = 4'd14; #1;
        checks++;
        if (read_data_o !== 4'b0110) $display("FAIL b2b_addr14 got %b want 0110", read_data_o);
        else passed++;
        read_addr_i = 4'd11; #1;
        checks++;
        if (read_data_o !== 4'b0000) $display("FAIL b2b_addr11 got %b want 0000", read_data_o);
        else passed++;
        checks++;
        if (pm_obs[3] !== 8'd28) $display("FAIL b2b_pm3 got %0d want 28", pm_obs[3]);
        else passed++;
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 4'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (pm_obs[n] !== m_pm[n]) $display("FAIL rand_pm%0d step %0d got %0d want %0d", n, i, pm_obs[n], m_pm[n]);
                else passed++;
            end
            for (int r = 0; r < 3; r++) begin
                a = $urandom_range(0, 15);
                read_addr_i = AW'(a); #1;
                checks++;
                if (read_data_o !== model_read(a)) $display("FAIL rand_hist[%0d] step %0d got %b want %b", a, i, read_data_o, model_read(a));
                else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b0; dec_bits_i = '0; read_addr_i = '0;
        pm_new_s0_i = '0; pm_new_s1_i = '0; pm_new_s2_i = '0; pm_new_s3_i = '0;
        for (int k = 0; k < TBL; k++) m_hist.push_back(4'b0000);
        for (int n = 0; n < 4; n++) m_pm[n] = '0;
        #1;
        test_reset();
        test_single_write();
        test_four_writes();
        test_fill_overflow();
        test_hold();
        test_out_of_range();
        test_reset_with_valid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/path_metric_unit.md
Name: path_metric_unit

Overview:
- Viterbi decoder storage block for a 4-state trellis.
- Holds the current path metrics (PM) of the 4 states, updated from the ACS stage on each valid trellis step.
- Holds a TBL-deep shift history of 4-bit survivor decision vectors, read at random by the traceback unit.
- Sits between the ACS units (writer) and the traceback unit (reader).

Parameters:
- TBL, 15, traceback length: number of decision vectors retained; legal range 2..64.
- PM_WIDTH, 8, path metric width in bits; legal range 2..32.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-high reset.
- valid_i, input, 1, trellis-step strobe; one update per cycle while high.
- dec_bits_i, input, 4, survivor decisions for states 0..3 (bit n = state n).
- pm_new_s0_i..pm_new_s3_i, input, PM_WIDTH each, new path metrics from ACS.
- read_addr_i, input, $clog2(TBL), decision history read address; 0 = oldest, TBL-1 = newest.
- pm_current_s0_o..pm_current_s3_o, output, PM_WIDTH each, registered current path metrics.
- read_data_o, output, 4, decision vector at read_addr_i.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high. Reset has priority over valid_i.
- Reset values: all four PM registers = 0; all TBL history entries = 0. Therefore read_data_o = 0 for any address after reset.
- PM update, rising edge with valid_i=1 and rst=0: pm_current_sN_o <= pm_new_sN_i for N=0..3.
  - Latency is 1 cycle; outputs come directly from registers.
  - No arithmetic, normalisation or saturation; values are stored verbatim, full width.
- PM hold: with valid_i=0, PM registers hold regardless of pm_new_*_i activity.
- History shift, same edge as a PM update (valid_i=1):
  - entry[k] <= entry[k+1] for k = 0..TBL-2;
  - entry[TBL-1] <= dec_bits_i;
  - old entry[0] is discarded (overflow drops the oldest, no flag).
  - With valid_i=0 the history holds.
- Read path:
  - read_data_o = entry[read_addr_i], combinational, no read latency.
  - On a write edge the output reflects shifted contents in the same cycle after the edge.
  - After j writes (j < TBL), entries TBL-j..TBL-1 hold the writes oldest to newest; the remaining entries stay 0.
- Out-of-range address (read_addr_i >= TBL, e.g. 15 when TBL=15): read_data_o = 0; no X propagation.
- Back-to-back valid_i on consecutive cycles is legal; each cycle is one step.
- Reset asserted mid-operation: at the next edge PMs and history clear to 0. A simultaneous valid_i is ignored.
- Known/unknown discipline: no latches; every register has a reset.

Decomposition:
- Shared package viterbi_pkg holds:
  - NUM_STATES = 4, DEC_W = 4;
  - default TBL and PM_WIDTH constants;
  - typedef for the PM word (logic [PM_WIDTH-1:0]);
  - typedef for the decision vector (logic [3:0]).
- One natural sub-module: decision_history_sreg.
  - Contains the TBL x 4 shift register plus the combinational read mux with out-of-range zeroing.
  - Parameterised by TBL.
  - The top level contains the four PM registers and instantiates it.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then release → all PM outputs 0; read_data_o = 0000 at addresses 0 and 14.
2. Single write: dec=1010, PMs 10/20/30/40, one valid pulse → PM outputs 10/20/30/40; addr14 = 1010, addr13 = 0000.
3. Four writes 0001, 0010, 0100, 1000, last PMs 170/180/190/200 → PMs 170/180/190/200; addr14=1000, addr13=0100, addr12=0010, addr11=0001, addr0=0000.
4. Fill and overflow: 15 writes of 1111 (PMs 255/254/253/252) → addr0 = 1111 and addr14 = 1111. Then one write of 0000 (PMs 1/2/3/4) → addr14=0000, addr0..13=1111, PMs 1/2/3/4.
5. Hold: valid_i=0, pm_new_s0_i=0 and pm_new_s1_i=0 for 2+ cycles → PM0 stays 1, PM1 stays 2; history unchanged.
6. Edge cases:
   - read_addr_i=15 → read_data_o=0000.
   - rst and valid_i high on the same edge → all state 0.
   - valid_i high for 3 consecutive cycles with 0011, 0101, 0110 → addr12/13/14 = 0011/0101/0110.
